// File: rtl/usr_ctrl_if.sv
// Bus between the usr_ctrl sequencer, its command source and the universal shift register.
// The slave modport is the sequencer; the master modport is the surrounding environment.
interface usr_ctrl_if #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned CNT_W = 3
);
    logic             start;
    logic             dir;
    logic [CNT_W-1:0] nshift;
    logic [WIDTH-1:0] din;
    logic [WIDTH-1:0] ser_data;
    logic [WIDTH-1:0] usr_pout;
    logic             s1;
    logic             s0;
    logic             sin;
    logic [WIDTH-1:0] pin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;

    modport slave (
        input  start, dir, nshift, din, ser_data, usr_pout,
        output s1, s0, sin, pin, busy, done, result
    );

    modport master (
        output start, dir, nshift, din, ser_data, usr_pout,
        input  s1, s0, sin, pin, busy, done, result
    );
endinterface

// File: rtl/usr_ctrl.sv
// Load / shift-N / capture sequencer for a universal shift register. Between operations the
// register is held by reloading it from result, since mode 00 clears it and never appears here.
module usr_ctrl #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned CNT_W = 3
) (
    input logic       clk,
    input logic       rst,
    usr_ctrl_if.slave bus
);
    typedef enum logic [1:0] {StIdle, StLoad, StShift, StCapture} state_e;

    localparam logic [CNT_W-1:0] MaxCnt    = CNT_W'(WIDTH);
    localparam logic [1:0]       ModeLoad  = 2'b11;
    localparam logic [1:0]       ModeLeft  = 2'b01;
    localparam logic [1:0]       ModeRight = 2'b10;

    state_e           state_q, state_d;
    logic [1:0]       mode_q, mode_d;
    logic             sin_q, sin_d;
    logic [WIDTH-1:0] pin_q, pin_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [WIDTH-1:0] ser_q, ser_d;
    logic             dir_q, dir_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] k_q, k_d;

    logic [CNT_W-1:0] k_nxt;
    logic [WIDTH-1:0] ser_sh;
    logic [1:0]       shift_mode;

    always_comb begin
        state_d    = state_q;
        mode_d     = ModeLoad;
        sin_d      = 1'b0;
        pin_d      = pin_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        result_d   = result_q;
        ser_d      = ser_q;
        dir_d      = dir_q;
        cnt_d      = cnt_q;
        k_d        = k_q;
        k_nxt      = k_q + CNT_W'(1);
        ser_sh     = ser_q >> k_nxt;
        shift_mode = dir_q ? ModeRight : ModeLeft;

        case (state_q)
            StIdle: begin
                pin_d  = result_q;
                busy_d = 1'b0;
                if (bus.start) begin
                    state_d = StLoad;
                    ser_d   = bus.ser_data;
                    dir_d   = bus.dir;
                    cnt_d   = (bus.nshift > MaxCnt) ? MaxCnt : bus.nshift;
                    // pin_q doubles as the latched din during LOAD.
                    pin_d   = bus.din;
                    busy_d  = 1'b1;
                end
            end
            StLoad: begin
                pin_d = '0;
                if (cnt_q == '0) begin
                    state_d = StCapture;
                    done_d  = 1'b1;
                end else begin
                    state_d = StShift;
                    k_d     = '0;
                    mode_d  = shift_mode;
                    sin_d   = ser_q[0];
                end
            end
            StShift: begin
                k_d = k_nxt;
                if (k_nxt == cnt_q) begin
                    state_d = StCapture;
                    done_d  = 1'b1;
                end else begin
                    mode_d = shift_mode;
                    sin_d  = ser_sh[0];
                end
            end
            StCapture: begin
                state_d  = StIdle;
                result_d = bus.usr_pout;
                pin_d    = bus.usr_pout;
                busy_d   = 1'b0;
                k_d      = '0;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            mode_q   <= ModeLoad;
            sin_q    <= 1'b0;
            pin_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
            ser_q    <= '0;
            dir_q    <= 1'b0;
            cnt_q    <= '0;
            k_q      <= '0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            sin_q    <= sin_d;
            pin_q    <= pin_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            result_q <= result_d;
            ser_q    <= ser_d;
            dir_q    <= dir_d;
            cnt_q    <= cnt_d;
            k_q      <= k_d;
        end
    end

    // CAPTURE reloads the register with its own value, the only combinational path.
    assign bus.pin    = (state_q == StCapture) ? bus.usr_pout : pin_q;
    assign bus.s1     = mode_q[1];
    assign bus.s0     = mode_q[0];
    assign bus.sin    = sin_q;
    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.result = result_q;
endmodule

// File: tb/tb_usr_ctrl.sv
// Scoreboard bench for usr_ctrl driving a behavioural universal shift register.
// Stimulus pushes expected results; a negedge monitor pops them whenever done is seen.
module tb_usr_ctrl;
    localparam int unsigned WIDTH = 4;
    localparam int unsigned CNT_W = 3;

    typedef struct {
        logic [WIDTH-1:0] res;
        int unsigned      n;
        logic             dir;
        int               t0;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    int               cyc = 0;
    int               n_checks = 0;
    int               n_fail = 0;
    exp_t             sb[$];
    logic [WIDTH-1:0] sr_q = 4'b1010;

    usr_ctrl_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

    usr_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural universal shift register.
    always @(posedge clk) begin
        case ({bus.s1, bus.s0})
            2'b00:   sr_q <= '0;
            2'b01:   sr_q <= {sr_q[WIDTH-2:0], bus.sin};
            2'b10:   sr_q <= {bus.sin, sr_q[WIDTH-1:1]};
            default: sr_q <= bus.pin;
        endcase
    end
    assign bus.usr_pout = sr_q;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int unsigned clamp_n(input logic [CNT_W-1:0] n);
        return (32'(n) > WIDTH) ? WIDTH : 32'(n);
    endfunction

    // Reference: shifting left doubles and appends the serial bit, right halves and
    // inserts it at the top.
    function automatic logic [WIDTH-1:0] ref_result(input logic [WIDTH-1:0] d, input logic dr,
                                                    input int unsigned n,
                                                    input logic [WIDTH-1:0] s);
        int unsigned v;
        int unsigned b;
        v = 32'(d);
        for (int k = 0; k < int'(n); k++) begin
            b = (32'(s) >> k) & 1;
            if (dr) v = v / 2 + b * (1 << (WIDTH - 1));
            else    v = (v * 2 + b) % (1 << WIDTH);
        end
        return WIDTH'(v);
    endfunction

    // Monitor.
    int               shifts_seen = 0;
    logic             bad_dir = 1'b0;
    logic             res_pend = 1'b0;
    logic [WIDTH-1:0] res_exp = '0;

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            shifts_seen = 0;
            bad_dir     = 1'b0;
            res_pend    = 1'b0;
        end else begin
            check("mode_not_00", 32'({bus.s1, bus.s0} == 2'b00), 32'd0);
            if (res_pend) begin
                check("result_reg", 32'(bus.result), 32'(res_exp));
                res_pend = 1'b0;
            end
            if (bus.s1 ^ bus.s0) begin
                shifts_seen++;
                if (sb.size() == 0 || bus.s1 != sb[0].dir) bad_dir = 1'b1;
            end
            if (bus.done) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_done: done=1, required 0 (cycle %0d)", cyc);
                end else begin
                    e = sb.pop_front();
                    check("capture_pout", 32'(bus.usr_pout), 32'(e.res));
                    check("capture_pin", 32'(bus.pin), 32'(e.res));
                    check("latency", 32'(cyc - e.t0), e.n + 2);
                    check("shift_cycles", 32'(shifts_seen), e.n);
                    check("shift_dir", 32'(bad_dir), 32'd0);
                    check("busy_capture", 32'(bus.busy), 32'd1);
                    res_exp  = e.res;
                    res_pend = 1'b1;
                end
                shifts_seen = 0;
                bad_dir     = 1'b0;
            end
        end
    end

    task automatic scramble();
        bus.din      = WIDTH'($urandom);
        bus.dir      = 1'($urandom_range(0, 1));
        bus.nshift   = CNT_W'($urandom);
        bus.ser_data = WIDTH'($urandom);
    endtask

    // Called at posedge+1 of an IDLE cycle; returns at posedge+1 of the LOAD cycle.
    task automatic do_op(input logic [WIDTH-1:0] d, input logic dr, input logic [CNT_W-1:0] n,
                         input logic [WIDTH-1:0] s);
        exp_t e;
        e.n   = clamp_n(n);
        e.dir = dr;
        e.res = ref_result(d, dr, e.n, s);
        e.t0  = cyc;
        sb.push_back(e);
        bus.start    = 1'b1;
        bus.din      = d;
        bus.dir      = dr;
        bus.nshift   = n;
        bus.ser_data = s;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        scramble();
    endtask

    task automatic wait_idle();
        bit ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(posedge clk);
            #1;
            ok = (sb.size() == 0) && !bus.busy;
        end
        if (!ok) begin
            n_checks++;
            n_fail++;
            $display("FAIL wait_idle_timeout: pending=%0d busy=%0b, required 0 and 0",
                     sb.size(), bus.busy);
            sb.delete();
        end
    endtask

    task automatic do_reset(input int ncyc);
        rst = 1'b1;
        sb.delete();
        repeat (ncyc) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_result", 32'(bus.result), 32'd0);
        check("rst_mode", 32'({bus.s1, bus.s0}), 32'd3);
        check("rst_pin", 32'(bus.pin), 32'd0);
        check("rst_sin", 32'(bus.sin), 32'd0);
        @(posedge clk);
        #1;
        check("rst_reg_cleared", 32'(bus.usr_pout), 32'd0);
    endtask

    initial begin
        bus.start = 1'b0;
        scramble();
        do_reset(2);

        // Directed cases.
        do_op(4'b1011, 1'b0, 3'd2, 4'b1101);
        wait_idle();
        repeat (10) begin
            check("hold_pout", 32'(bus.usr_pout), 32'b1110);
            check("hold_mode", 32'({bus.s1, bus.s0}), 32'd3);
            @(posedge clk);
            #1;
        end
        do_op(4'b1000, 1'b1, 3'd3, 4'b1011);
        wait_idle();
        do_op(4'b0101, 1'b1, 3'd0, 4'b1111);
        wait_idle();
        do_op(4'b1111, 1'b0, 3'd7, 4'b0000);
        wait_idle();

        // Start pulsed mid-SHIFT must be ignored.
        do_op(4'b0110, 1'b1, 3'd4, 4'b1001);
        @(posedge clk);
        #1;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        wait_idle();
        repeat (4) @(posedge clk);
        #1;

        // Reset during the second shift of a 4-shift operation.
        do_op(4'b1001, 1'b0, 3'd4, 4'b0110);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        do_reset(1);
        do_op(4'b0011, 1'b1, 3'd1, 4'b0001);
        wait_idle();

        // Random operations with a 2-cycle reset mid-stream.
        for (int i = 0; i < 40; i++) begin
            do_op(WIDTH'($urandom), 1'($urandom_range(0, 1)), CNT_W'($urandom_range(0, 7)),
                  WIDTH'($urandom));
            if (i == 20) do_reset(2);
            else wait_idle();
        end

        repeat (3) @(posedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not reach the summary line");
        $fatal(1, "timeout");
    end
endmodule
